// File: rtl/serv_immdec_w.sv
// Bit-serial RISC-V immediate decoder: captures instr[31:7] and streams the 32-bit immediate LSB first, W bits per chunk.
// Optional macro SERV_IMMDEC_CSR_IMM_EN enables streaming of the zero-extended CSR zimm on o_csr_imm.
module serv_immdec_w #(
  parameter int W = 1,
  localparam int CW = ($clog2(32 / W) < 1) ? 1 : $clog2(32 / W)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_en,
  input  logic [24:0]   i_wb_rdt,
  input  logic [2:0]    i_fmt,
  input  logic          i_cnt_en,
  output logic [4:0]    o_rd_addr,
  output logic [4:0]    o_rs1_addr,
  output logic [4:0]    o_rs2_addr,
  output logic [W-1:0]  o_imm,
  output logic [W-1:0]  o_csr_imm,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);

  generate
    if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
      $error("serv_immdec_w: W must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [CW-1:0] LAST_IDX = CW'(32 / W - 1);

  logic [24:0]   ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   imm;
  logic [31:0]   imm_sh;

  // ir holds instr[31:7], so instr[k] lives at ir[k-7]
  function automatic logic [31:0] build_imm(input logic [24:0] ir, input logic [2:0] fmt);
    logic signed [31:0] v;
    case (fmt)
      3'd1:    v = {{20{ir[24]}}, ir[24:18], ir[4:0]};
      3'd2:    v = {{20{ir[24]}}, ir[0], ir[23:18], ir[4:1], 1'b0};
      3'd3:    v = {ir[24:5], 12'b0};
      3'd4:    v = {{12{ir[24]}}, ir[12:5], ir[13], ir[23:14], 1'b0};
      default: v = {{20{ir[24]}}, ir[24:13]};
    endcase
    return v;
  endfunction

  always_comb begin
    ir_d  = ir_q;
    cnt_d = cnt_q;
    if (i_wb_en) begin
      ir_d  = i_wb_rdt;
      cnt_d = '0;
    end else if (i_cnt_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ir_q  <= '0;
      cnt_q <= '0;
    end else begin
      ir_q  <= ir_d;
      cnt_q <= cnt_d;
    end
  end

  assign imm    = build_imm(ir_q, i_fmt);
  assign imm_sh = imm >> (int'(cnt_q) * W);

  assign o_rd_addr  = ir_q[4:0];
  assign o_rs1_addr = ir_q[12:8];
  assign o_rs2_addr = ir_q[17:13];
  assign o_imm      = imm_sh[W-1:0];
  assign o_cnt      = cnt_q;
  assign o_last     = (cnt_q == LAST_IDX);

`ifdef SERV_IMMDEC_CSR_IMM_EN
  logic [31:0] zimm_sh;
  assign zimm_sh   = {27'b0, ir_q[12:8]} >> (int'(cnt_q) * W);
  assign o_csr_imm = zimm_sh[W-1:0];
`else
  assign o_csr_imm = '0;
`endif

endmodule

// File: tb/tb_serv_immdec_w.sv
// Self-checking bench for serv_immdec_w: four widths (W=1,2,4,8) share one stimulus stream against a behavioural model.
module tb_serv_immdec_w;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_en = 1'b0;
  logic [24:0] rdt = '0;
  logic [2:0]  fmt = '0;
  logic        cnt_en = 1'b0;

  always #5 clk = ~clk;

  logic [4:0] rd1, rs11, rs21, rd2, rs12, rs22, rd4, rs14, rs24, rd8, rs18, rs28;
  logic [0:0] imm1, csr1;
  logic [1:0] imm2, csr2;
  logic [3:0] imm4, csr4;
  logic [7:0] imm8, csr8;
  logic [4:0] cnt1;
  logic [3:0] cnt2;
  logic [2:0] cnt4;
  logic [1:0] cnt8;
  logic       last1, last2, last4, last8;

  serv_immdec_w #(.W(1)) u1 (.i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_rdt(rdt), .i_fmt(fmt),
    .i_cnt_en(cnt_en), .o_rd_addr(rd1), .o_rs1_addr(rs11), .o_rs2_addr(rs21), .o_imm(imm1),
    .o_csr_imm(csr1), .o_cnt(cnt1), .o_last(last1));
  serv_immdec_w #(.W(2)) u2 (.i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_rdt(rdt), .i_fmt(fmt),
    .i_cnt_en(cnt_en), .o_rd_addr(rd2), .o_rs1_addr(rs12), .o_rs2_addr(rs22), .o_imm(imm2),
    .o_csr_imm(csr2), .o_cnt(cnt2), .o_last(last2));
  serv_immdec_w #(.W(4)) u4 (.i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_rdt(rdt), .i_fmt(fmt),
    .i_cnt_en(cnt_en), .o_rd_addr(rd4), .o_rs1_addr(rs14), .o_rs2_addr(rs24), .o_imm(imm4),
    .o_csr_imm(csr4), .o_cnt(cnt4), .o_last(last4));
  serv_immdec_w #(.W(8)) u8 (.i_clk(clk), .i_rst_n(rst_n), .i_wb_en(wb_en), .i_wb_rdt(rdt), .i_fmt(fmt),
    .i_cnt_en(cnt_en), .o_rd_addr(rd8), .o_rs1_addr(rs18), .o_rs2_addr(rs28), .o_imm(imm8),
    .o_csr_imm(csr8), .o_cnt(cnt8), .o_last(last8));

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: last captured instruction and number of enabled cycles since capture.
  logic [31:0] m_instr = '0;
  int          m_k     = 0;
  bit          chk_en  = 1'b0;

`ifdef SERV_IMMDEC_CSR_IMM_EN
  localparam bit CSR_ON = 1'b1;
`else
  localparam bit CSR_ON = 1'b0;
`endif

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Immediate formats written out as the ISA defines them on the full 32-bit word.
  function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] f);
    case (f)
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'b0};
      3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  task automatic cmp_inst(input string tag, input int w, input longint cnt, input longint last,
                          input longint imm, input longint csr, input longint rd, input longint rs1,
                          input longint rs2);
    int n, c;
    longint mask, zimm;
    n    = 32 / w;
    c    = m_k % n;
    mask = (64'd1 << w) - 1;
    zimm = CSR_ON ? longint'(m_instr[19:15]) : 0;
    check({tag, "_cnt"}, cnt, c);
    check({tag, "_last"}, last, (c == n - 1) ? 1 : 0);
    check({tag, "_imm"}, imm, (longint'(ref_imm(m_instr, fmt)) >> (c * w)) & mask);
    check({tag, "_csr"}, csr, (zimm >> (c * w)) & mask);
    check({tag, "_rd"}, rd, m_instr[11:7]);
    check({tag, "_rs1"}, rs1, m_instr[19:15]);
    check({tag, "_rs2"}, rs2, m_instr[24:20]);
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      cmp_inst("w1", 1, cnt1, last1, imm1, csr1, rd1, rs11, rs21);
      cmp_inst("w2", 2, cnt2, last2, imm2, csr2, rd2, rs12, rs22);
      cmp_inst("w4", 4, cnt4, last4, imm4, csr4, rd4, rs14, rs24);
      cmp_inst("w8", 8, cnt8, last8, imm8, csr8, rd8, rs18, rs28);
    end
  end

  task automatic cyc(input logic wb, input logic [31:0] ins, input logic [2:0] f, input logic ce);
    wb_en  = wb;
    rdt    = ins[31:7];
    fmt    = f;
    cnt_en = ce;
    @(posedge clk);
    if (rst_n) begin
      if (wb) begin
        m_instr = ins;
        m_k     = 0;
      end else if (ce) begin
        m_k++;
      end
    end
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w4_cnt"}, cnt4, 0);
    check({tag, "_w4_imm"}, imm4, 0);
    check({tag, "_w4_last"}, last4, 0);
    check({tag, "_w4_rd"}, rd4, 0);
    check({tag, "_w4_rs1"}, rs14, 0);
    check({tag, "_w4_rs2"}, rs24, 0);
    check({tag, "_w4_csr"}, csr4, 0);
    check({tag, "_w1_imm"}, imm1, 0);
    check({tag, "_w8_imm"}, imm8, 0);
    check({tag, "_w1_last"}, last1, 0);
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  rf;
    // Model pins against hand-computed immediates.
    check("pin_I", ref_imm(32'hFFF10093, 3'd0), 32'hFFFF_FFFF);
    check("pin_S", ref_imm(32'h00532423, 3'd1), 32'h0000_0008);
    check("pin_B", ref_imm(32'hFE000EE3, 3'd2), 32'hFFFF_FFFC);
    check("pin_U", ref_imm(32'h123450B7, 3'd3), 32'h1234_5000);
    check("pin_J", ref_imm(32'h0010006F, 3'd4), 32'h0000_0800);
    check("pin_rsv", ref_imm(32'hFFF10093, 3'd6), 32'hFFFF_FFFF);

    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // I-format
    cyc(1'b1, 32'hFFF10093, 3'd0, 1'b0);
    check("I_rd", rd4, 5'd1);
    check("I_rs1", rs14, 5'd2);
    check("I_chunk0", imm4, 4'hF);
    for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, 3'd0, 1'b1);
    check("I_last7", last4, 1'b1);
    check("I_cnt7", cnt4, 3'd7);
    cyc(1'b0, 32'h0, 3'd0, 1'b1);
    check("I_wrap", cnt4, 3'd0);
    check("I_wrap_last", last4, 1'b0);

    // S-format
    cyc(1'b1, 32'h00532423, 3'd1, 1'b0);
    check("S_rs1", rs11, 5'd6);
    check("S_rs2", rs21, 5'd5);
    for (int i = 0; i < 32; i++) begin
      if (i == 3) check("S_bit3", imm1, 1'b1);
      cyc(1'b0, 32'h0, 3'd1, 1'b1);
    end

    // B-format then U-format
    cyc(1'b1, 32'hFE000EE3, 3'd2, 1'b0);
    check("B_chunk0", imm8, 8'hFC);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 3'd2, 1'b1);
    cyc(1'b1, 32'h123450B7, 3'd3, 1'b0);
    check("U_chunk0", imm8, 8'h00);
    cyc(1'b0, 32'h0, 3'd3, 1'b1);
    check("U_chunk1", imm8, 8'h50);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 3'd3, 1'b1);

    // J-format with capture and advance on the same edge
    cyc(1'b0, 32'h0, 3'd4, 1'b1);
    cyc(1'b1, 32'h0010006F, 3'd4, 1'b1);
    check("J_collide_cnt", cnt2, 4'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) check("J_chunk5", imm2, 2'b10);
      cyc(1'b0, 32'h0, 3'd4, 1'b1);
    end

    // CSR zimm = 5'b10110
    cyc(1'b1, 32'h000B0000, 3'd0, 1'b0);
    check("CSR_bit0", csr1, 1'b0);
    cyc(1'b0, 32'h0, 3'd0, 1'b1);
    check("CSR_bit1", csr1, CSR_ON ? 1'b1 : 1'b0);
    for (int i = 0; i < 31; i++) cyc(1'b0, 32'h0, 3'd0, 1'b1);

    // Hold: no enable keeps everything stable
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 3'd0, 1'b0);

    // Asynchronous reset mid-stream at cnt=3
    cyc(1'b1, 32'hFFF10093, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 3'd0, 1'b1);
    check("rst_pre_cnt", cnt4, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    m_instr = '0;
    m_k     = 0;
    cyc(1'b0, 32'h0, 3'd0, 1'b1);
    check("rst_hold_cnt", cnt4, 3'd0);
    rst_n = 1'b1;
    #1;
    check("rst_rel_cnt", cnt4, 3'd0);
    check("rst_rel_imm", imm4, 4'h0);

    // Randomised traffic
    rf = 3'd0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        rf = 3'($urandom_range(0, 7));
        cyc(1'b1, r, rf, 1'($urandom_range(0, 1)));
      end else begin
        cyc(1'b0, r, rf, ($urandom_range(0, 3) != 0));
      end
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serv_immdec_w.md
# serv_immdec_w

Parametrised bit-serial immediate decoder for the SERV core. It latches a fetched instruction on the Wishbone read strobe and presents the register addresses. It also streams the sign-extended 32-bit immediate, LSB first, W bits per enabled cycle. It replaces the fixed 1-bit decoder: the datapath width W is selectable, a chunk counter is held internally, and the format is selected explicitly.

## Interface
Parameters:
- W, default 1: bits delivered per enabled cycle. Legal values are 1, 2, 4, 8; any other value is an elaboration error.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_wb_en, input, 1: instruction-capture strobe (Wishbone ack of the fetch).
- i_wb_rdt, input, 25: instruction bits [31:7].
- i_fmt, input, 3: immediate format. 0=I, 1=S, 2=B, 3=U, 4=J; codes 5–7 are reserved and decode as I.
- i_cnt_en, input, 1: advance one chunk.
- o_rd_addr, output, 5: instr[11:7].
- o_rs1_addr, output, 5: instr[19:15].
- o_rs2_addr, output, 5: instr[24:20].
- o_imm, output, W: current immediate chunk.
- o_csr_imm, output, W: current chunk of the zero-extended zimm (instr[19:15]).
- o_cnt, output, log2(32/W) bits, minimum 1: current chunk index.
- o_last, output, 1: the current chunk is the final one.

## Operation
- Capture:
  - When i_wb_en=1 at a clock edge, latch i_wb_rdt into a 25-bit instruction register.
  - The same edge clears the chunk counter to 0.
- Register addresses are driven directly from the instruction register. They stay stable until the next capture.
- Immediate construction, standard RISC-V:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- i_fmt is sampled combinationally every cycle. It must be held stable by the controller for the whole sequence.
- Streaming:
  - o_imm = imm[cnt*W + W-1 : cnt*W].
  - o_csr_imm = zimm[cnt*W + W-1 : cnt*W], where zimm = {27'b0, instr[19:15]}.
- Counter:
  - Increments on each edge with i_cnt_en=1 and i_wb_en=0.
  - Wraps from 32/W-1 to 0.
  - o_last = (cnt == 32/W-1).
- Simultaneous i_wb_en and i_cnt_en: capture wins, the counter goes to 0 and no advance occurs.
- i_cnt_en=0: the counter holds and the outputs are stable.
- Shift-register implementation is permitted provided the outputs are identical.

## Timing
- Reset (i_rst_n=0, asynchronous assert, synchronous deassert via the core's reset synchroniser):
  - The instruction register and counter clear to 0.
  - o_rd_addr, o_rs1_addr, o_rs2_addr, o_cnt, o_imm and o_csr_imm are all 0.
  - o_last is 0, except for W=32 (not legal, so it is always 0 at reset).
- Capture latency: outputs reflect the new instruction in the cycle after the capture edge, with chunk 0 presented.
- A full immediate takes exactly 32/W enabled cycles. The chunk for index k is valid combinationally while cnt=k.
- Reset mid-stream aborts immediately, returns to the reset values and leaves no residual state.
- There is no combinational path from i_cnt_en to any output. Only i_fmt reaches o_imm combinationally.

## Configuration
- Macro SERV_IMMDEC_CSR_IMM_EN:
  - Defined: o_csr_imm streams zimm as specified.
  - Undefined: o_csr_imm is tied to 0, and no zimm muxing logic is generated.
- The instruction register width, the rest of the timing and all other outputs are unchanged by this macro.

## Test plan
- Reset, W=4: assert i_rst_n=0 mid-stream at cnt=3 -> all outputs 0 asynchronously; after release, cnt=0 and o_imm=0.
- I-format, W=4: capture 0xFFF10093 (addi x1,x2,-1), fmt=0, 8 enables -> o_imm=0xF every chunk, o_last only on cnt=7, rd=1, rs1=2, then wrap to cnt=0.
- S-format, W=1: capture 0x00532423 (sw x5,8(x6)), fmt=1 -> o_imm=1 only at cnt=3, 0 elsewhere over 32 cycles, rs1=6, rs2=5.
- B-format and U-format, W=8:
  - 0xFE000EE3 fmt=2 -> chunks FC,FF,FF,FF.
  - 0x123450B7 fmt=3 -> chunks 00,50,34,12.
- J-format, W=2, collision: capture 0x0010006F fmt=4, assert i_cnt_en together with i_wb_en -> cnt stays 0. Then stream imm=0x800: only chunk 5 equals 2'b10.
- CSR immediate, W=1, with the macro defined: capture instr[19:15]=5'b10110 -> o_csr_imm streams 0,1,1,0,1 then 0 for cnt 5–31. Without the macro, o_csr_imm is constant 0.
